sum_pack_buffer: RTL and testbench
==================================

Name: sum_pack_buffer

Overview:
- Sits directly downstream of the calculator controller.
- Takes the controller's adder operands (op_a, op_b), forms their 32-bit sum, and packs two consecutive sums into one MEM_WORD_SIZE result word.
- The result word is exposed as buff_result, which the controller splits into w_data_a (upper half) and w_data_b (lower half) for the SRAM write.
- Also tracks half-valid status, sticky carry overflow, overrun errors and a saturating count of adds, for debug and verification.

Parameters:
- DATA_W, 32, operand and sum width; one half of the packed word.
- MEM_WORD_SIZE, 64, packed result width; must equal 2*DATA_W.
- CNT_W, 16, width of the saturating add counter.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- op_a  in  DATA_W  adder operand A from controller.
- op_b  in  DATA_W  adder operand B from controller.
- buffer_write  in  1  active-low load strobe; 0 = add and store this cycle.
- buffer_control  in  1  half select; 1 = upper [MEM_WORD_SIZE-1:DATA_W], 0 = lower [DATA_W-1:0].
- write  in  1  active-low SRAM write strobe from controller; 0 = packed word consumed this cycle.
- clear_i  in  1  synchronous clear of contents and flags (active-high).
- buff_result  out  MEM_WORD_SIZE  registered packed result word.
- word_valid  out  1  both halves loaded since last consume.
- half_valid  out  2  {upper, lower} loaded flags.
- overflow  out  1  sticky; some add produced a carry out of DATA_W.
- overrun  out  1  sticky; a half was reloaded before consumption.
- add_count  out  CNT_W  number of loads performed, saturating.

Behaviour:
- Reset: when rst_i=1 at an edge, all of the following go to 0: buff_result, half_valid, word_valid, overflow, overrun, add_count. FSM goes to S_EMPTY. Reset mid-sequence discards any partial word.
- Priority order: rst_i, then clear_i, then normal operation.
- clear_i=1: same effect as reset, but driven from the datapath rather than the system reset.
- Sum: {carry, sum} = op_a + op_b, computed at (DATA_W+1) bits. sum is the low DATA_W bits; the carry is discarded from the data.
- Load (buffer_write=0):
  - sum is registered into the half selected by buffer_control; the other half is unchanged.
  - Latency is 1 cycle: the new value is visible on buff_result at the edge after the strobe.
  - The selected half_valid bit is set.
  - overflow |= carry.
  - add_count increments, holding at 2^CNT_W-1 once it reaches that value.
- Consume (write=0): both half_valid bits clear at the edge. buff_result data is held, not zeroed, so the SRAM write of the same cycle sees stable data.
- Simultaneous load and consume: the consume clears both flags first, then the load sets its own half flag and writes its data. The next state therefore counts only the new half.
- Overrun: a load to a half whose valid bit is 1 and that is not being consumed in the same cycle sets overrun (sticky). The data is still overwritten.
- word_valid = half_valid[1] & half_valid[0], registered through the FSM.
- FSM states: S_EMPTY, S_HALF, S_FULL.
  - S_EMPTY: load goes to S_HALF; otherwise stay.
  - S_HALF, load into the other half: go to S_FULL.
  - S_HALF, load into the same half: stay, and flag overrun.
  - S_HALF, consume without load: go to S_EMPTY.
  - S_HALF, consume with load: stay.
  - S_FULL, consume without load: go to S_EMPTY.
  - S_FULL, consume with load: go to S_HALF.
  - S_FULL, load without consume: stay, and flag overrun.
  - In every state, clear_i or rst_i goes to S_EMPTY.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- The write strobe is ignored while in S_EMPTY: no flag change and no error.

Test Plan:
- Reset then idle 5 cycles -> buff_result=0, all flags 0, add_count=0, and the FSM remains in S_EMPTY.
- Load lower: op_a=5, op_b=7, control=0, then load upper: op_a=0x10, op_b=0x20, control=1.
  - -> buff_result=0x00000030_0000000C.
  - -> word_valid=1 one cycle after the second load.
  - -> add_count=2, overflow=0.
- Full word, then write=0 for 1 cycle -> half_valid=00 and word_valid=0 next cycle; buff_result still 0x00000030_0000000C.
- op_a=0xFFFFFFFF, op_b=2, control=0 -> lower half=0x00000001 and overflow=1; overflow stays 1 after a subsequent consume.
- Two consecutive lower loads without a consume (values 1+1, then 2+2) -> lower half=4 and overrun=1. Repeat with a same-cycle consume: overrun stays 0 and half_valid=01.
- Assert rst_i in S_HALF, and separately clear_i in S_FULL -> next cycle all outputs are 0. Then issue 2^CNT_W+3 loads -> add_count saturates at 0xFFFF.

Source files
------------

// File: rtl/sum_pack_buffer_if.sv
// Bundles the controller-facing operand, strobe and status signals of the sum pack buffer.
// The master side is the calculator controller and the slave side is the buffer.
interface sum_pack_buffer_if #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_WORD_SIZE = 64,
    parameter int unsigned CNT_W         = 16
);
    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        op_b;
    logic                     buffer_write;
    logic                     buffer_control;
    logic                     write;
    logic                     clear_i;
    logic [MEM_WORD_SIZE-1:0] buff_result;
    logic                     word_valid;
    logic [1:0]               half_valid;
    logic                     overflow;
    logic                     overrun;
    logic [CNT_W-1:0]         add_count;

    modport master (
        output op_a, op_b, buffer_write, buffer_control, write, clear_i,
        input  buff_result, word_valid, half_valid, overflow, overrun, add_count
    );

    modport slave (
        input  op_a, op_b, buffer_write, buffer_control, write, clear_i,
        output buff_result, word_valid, half_valid, overflow, overrun, add_count
    );
endinterface

// File: rtl/sum_pack_buffer.sv
// Adds the controller operands and packs two consecutive sums into one memory word,
// tracking half-valid status, sticky carry/overrun errors and a saturating add count.
module sum_pack_buffer #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_WORD_SIZE = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sum_pack_buffer_if.slave bus
);
    localparam int unsigned SUM_W = DATA_W + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state;
    logic [MEM_WORD_SIZE-1:0] r_buff;
    logic [MEM_WORD_SIZE-1:0] w_buff;
    logic [1:0]               r_half_valid;
    logic [1:0]               w_half_valid;
    logic                     r_word_valid;
    logic                     r_overflow;
    logic                     w_overflow;
    logic                     r_overrun;
    logic                     w_overrun;
    logic [CNT_W-1:0]         r_add_count;
    logic [CNT_W-1:0]         w_add_count;

    logic                     w_load;
    logic                     w_consume;
    logic [SUM_W-1:0]         w_sum_full;
    logic [DATA_W-1:0]        w_sum;
    logic                     w_carry;

    // Strobes are active-low; a consume has nothing to act on while empty.
    assign w_load     = ~bus.buffer_write;
    assign w_consume  = ~bus.write & (r_state != S_EMPTY);
    assign w_sum_full = SUM_W'(bus.op_a) + SUM_W'(bus.op_b);
    assign w_sum      = w_sum_full[DATA_W-1:0];
    assign w_carry    = w_sum_full[DATA_W];

    // Next-state and next-value logic; consume clears flags before a same-cycle load sets its half.
    always_comb begin
        w_state      = r_state;
        w_buff       = r_buff;
        w_half_valid = r_half_valid;
        w_overflow   = r_overflow;
        w_overrun    = r_overrun;
        w_add_count  = r_add_count;

        if (bus.clear_i) begin
            w_state      = S_EMPTY;
            w_buff       = '0;
            w_half_valid = '0;
            w_overflow   = 1'b0;
            w_overrun    = 1'b0;
            w_add_count  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_load) w_state = S_HALF;
                end
                S_HALF: begin
                    if (w_consume)
                        w_state = w_load ? S_HALF : S_EMPTY;
                    else if (w_load && !r_half_valid[bus.buffer_control])
                        w_state = S_FULL;
                end
                S_FULL: begin
                    if (w_consume)
                        w_state = w_load ? S_HALF : S_EMPTY;
                end
                default: w_state = S_EMPTY;
            endcase

            if (w_load && r_half_valid[bus.buffer_control] && !w_consume)
                w_overrun = 1'b1;

            if (w_consume)
                w_half_valid = '0;

            if (w_load) begin
                w_half_valid[bus.buffer_control] = 1'b1;
                if (bus.buffer_control)
                    w_buff[MEM_WORD_SIZE-1:DATA_W] = w_sum;
                else
                    w_buff[DATA_W-1:0] = w_sum;
                w_overflow = r_overflow | w_carry;
                if (r_add_count != {CNT_W{1'b1}})
                    w_add_count = r_add_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_EMPTY;
            r_buff       <= '0;
            r_half_valid <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_overrun    <= 1'b0;
            r_add_count  <= '0;
        end else begin
            r_state      <= w_state;
            r_buff       <= w_buff;
            r_half_valid <= w_half_valid;
            r_word_valid <= (w_state == S_FULL);
            r_overflow   <= w_overflow;
            r_overrun    <= w_overrun;
            r_add_count  <= w_add_count;
        end
    end

    assign bus.buff_result = r_buff;
    assign bus.half_valid  = r_half_valid;
    assign bus.word_valid  = r_word_valid;
    assign bus.overflow    = r_overflow;
    assign bus.overrun     = r_overrun;
    assign bus.add_count   = r_add_count;
endmodule

// File: tb/tb_sum_pack_buffer.sv
// Directed and random checks of sum_pack_buffer against a scoreboarded reference model.
module tb_sum_pack_buffer;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_W  = 64;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [MEM_W-1:0] buff;
        logic [1:0]       hv;
        logic             wv;
        logic             ovf;
        logic             ovr;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    obs_t             sb_q[$];
    logic [MEM_W-1:0] m_buff = '0;
    logic [1:0]       m_hv   = '0;
    logic             m_ovf  = 1'b0;
    logic             m_ovr  = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;

    sum_pack_buffer_if #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W), .CNT_W(CNT_W)) bus ();

    sum_pack_buffer #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [MEM_W-1:0] obs, input logic [MEM_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written as a procedural update of the expected state.
    task automatic model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic bw, input logic bc, input logic wr,
                         input logic clr, input logic rs);
        logic [DATA_W:0] s;
        logic            ld;
        logic            cons;
        s    = {1'b0, a} + {1'b0, b};
        ld   = !bw;
        cons = !wr && (m_hv != 2'b00);
        if (rs || clr) begin
            m_buff = '0; m_hv = '0; m_ovf = 1'b0; m_ovr = 1'b0; m_cnt = '0;
        end else begin
            if (ld && m_hv[bc] && !cons) m_ovr = 1'b1;
            if (cons) m_hv = 2'b00;
            if (ld) begin
                if (bc) m_buff[63:32] = s[31:0];
                else    m_buff[31:0]  = s[31:0];
                m_hv[bc] = 1'b1;
                if (s[32]) m_ovf = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic step(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic bw, input logic bc, input logic wr,
                        input logic clr, input logic rs, input bit chk);
        obs_t e;
        @(negedge clk);
        bus.op_a = a; bus.op_b = b;
        bus.buffer_write = bw; bus.buffer_control = bc;
        bus.write = wr; bus.clear_i = clr; rst = rs;
        model(a, b, bw, bc, wr, clr, rs);
        if (chk) sb_q.push_back('{m_buff, m_hv, m_hv[1] & m_hv[0], m_ovf, m_ovr, m_cnt});
        @(posedge clk);
        #1;
        if (chk) begin
            e = sb_q.pop_front();
            cmp("buff_result", bus.buff_result, e.buff);
            cmp("half_valid", 64'(bus.half_valid), 64'(e.hv));
            cmp("word_valid", 64'(bus.word_valid), 64'(e.wv));
            cmp("overflow", 64'(bus.overflow), 64'(e.ovf));
            cmp("overrun", 64'(bus.overrun), 64'(e.ovr));
            cmp("add_count", 64'(bus.add_count), 64'(e.cnt));
        end
    endtask

    task automatic idle();
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic bc, input logic wr);
        step(a, b, 1'b0, bc, wr, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.op_a = '0; bus.op_b = '0;
        bus.buffer_write = 1'b1; bus.buffer_control = 1'b0;
        bus.write = 1'b1; bus.clear_i = 1'b0;

        // Reset then idle, including a stray consume while empty.
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("empty_buff", bus.buff_result, 64'h0);
        cmp("empty_cnt", 64'(bus.add_count), 64'h0);

        // Pack two sums.
        load(32'd5, 32'd7, 1'b0, 1'b1);
        cmp("lower_only_wv", 64'(bus.word_valid), 64'h0);
        load(32'h10, 32'h20, 1'b1, 1'b1);
        cmp("packed_word", bus.buff_result, 64'h00000030_0000000C);
        cmp("packed_wv", 64'(bus.word_valid), 64'h1);
        cmp("packed_cnt", 64'(bus.add_count), 64'h2);
        cmp("packed_ovf", 64'(bus.overflow), 64'h0);

        // Consume holds data.
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("consume_hv", 64'(bus.half_valid), 64'h0);
        cmp("consume_hold", bus.buff_result, 64'h00000030_0000000C);

        // Carry out sets sticky overflow.
        load(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        cmp("carry_lower", 64'(bus.buff_result[31:0]), 64'h1);
        cmp("carry_ovf", 64'(bus.overflow), 64'h1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("ovf_sticky", 64'(bus.overflow), 64'h1);

        // Overrun on same-half reload, then none with same-cycle consume.
        load(32'd1, 32'd1, 1'b0, 1'b1);
        load(32'd2, 32'd2, 1'b0, 1'b1);
        cmp("ovr_lower", 64'(bus.buff_result[31:0]), 64'h4);
        cmp("ovr_set", 64'(bus.overrun), 64'h1);
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load(32'd1, 32'd1, 1'b0, 1'b1);
        load(32'd2, 32'd2, 1'b0, 1'b0);
        cmp("noovr", 64'(bus.overrun), 64'h0);
        cmp("noovr_hv", 64'(bus.half_valid), 64'h1);

        // Overrun on a full word, and reset in the half state.
        load(32'd9, 32'd9, 1'b1, 1'b1);
        load(32'd3, 32'd3, 1'b1, 1'b1);
        cmp("full_ovr", 64'(bus.overrun), 64'h1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load(32'd4, 32'd4, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cmp("rst_half_buff", bus.buff_result, 64'h0);

        // Clear in the full state.
        load(32'd1, 32'd2, 1'b0, 1'b1);
        load(32'd3, 32'd4, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cmp("clr_full_wv", 64'(bus.word_valid), 64'h0);

        // Random traffic through the scoreboard.
        for (int i = 0; i < 60; i++)
            step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'b0, 1'b1);

        // Counter saturation.
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 65539; i++)
            step(32'(i), 32'd1, 1'b0, 1'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("sat_cnt", 64'(bus.add_count), 64'hFFFF);
        load(32'd1, 32'd1, 1'b0, 1'b0);
        cmp("sat_hold", 64'(bus.add_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
